// File: rtl/allophone_feeder.sv
// -----------------------------------------------------------------------------
// allophone_feeder
//
// Host-side transmitter for the Speech256 allophone load interface. A host
// (CPU or UART bridge) writes 6-bit allophone codes into a small FIFO. Each
// code goes to the speech core, in order, one code per load request, using the
// ldq / data_stb handshake.
//
// Parameters
//   FIFO_AW      log2 of the FIFO depth (depth = 2**FIFO_AW codes)
//   LDQ_TIMEOUT  longest wait, in cycles, for spk_ldq to drop after a strobe
//                (must be >= 2)
//
// Ports
//   clk          global Speech256 clock
//   rst          synchronous reset, active high
//   host_data    allophone code from the host
//   host_stb     one-cycle write strobe for host_data
//   host_full    FIFO full; writes made while it is high are dropped
//   host_level   current FIFO fill count (FIFO_AW+1 bits)
//   flush        synchronous clear of the FIFO, the FSM and the error flags
//   spk_ldq      load request from the speech core (high = can accept)
//   spk_data     allophone code to the speech core data_in
//   spk_stb      one-cycle strobe to the speech core data_stb
//   busy         FIFO non-empty, or FSM not idle, or strobe in flight
//   ovf          sticky: a write was attempted while the FIFO was full
//   timeout_err  sticky: spk_ldq did not drop within LDQ_TIMEOUT cycles
// -----------------------------------------------------------------------------
module allophone_feeder #(
    parameter int FIFO_AW     = 4,
    parameter int LDQ_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       host_data,
    input  logic             host_stb,
    output logic             host_full,
    output logic [FIFO_AW:0] host_level,
    input  logic             flush,
    input  logic             spk_ldq,
    output logic [5:0]       spk_data,
    output logic             spk_stb,
    output logic             busy,
    output logic             ovf,
    output logic             timeout_err
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = $clog2(LDQ_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LDQ_TIMEOUT - 1);
    localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [0:0] {
        IDLE,
        WAIT_LOW
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [5:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               fifo_empty;
    logic               push;
    logic               issue;
    logic               timeout_hit;

    assign fifo_empty = (level_q == '0);
    assign host_full  = (level_q == FULL_LEVEL);
    assign host_level = level_q;
    assign busy       = !fifo_empty || (state_q != IDLE) || spk_stb;

    // Fullness is taken from the registered level, so a write that meets a
    // full FIFO is dropped even if a pop happens on the same edge.
    assign push = host_stb && !host_full && !flush && !rst;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge, whatever the order of
    // the blocks.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb block gets a default
    // first. Without it, a path that does not assign the signal infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (issue) state_d = WAIT_LOW;
            WAIT_LOW: if (!spk_ldq || timeout_hit) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM decoded actions
    // -------------------------------------------------------------------------
    always_comb begin
        issue       = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE:     issue       = !fifo_empty && spk_ldq;
            WAIT_LOW: timeout_hit = spk_ldq && (cnt_q == CNT_LAST);
            default:  ;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset. The pointers and the level decide
    // which entries are valid, so clearing the array would only add logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, level, handshake outputs and sticky flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            spk_data    <= '0;
            spk_stb     <= 1'b0;
            ovf         <= 1'b0;
            timeout_err <= 1'b0;
        end else if (flush) begin
            // spk_data deliberately keeps the last issued code.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            spk_stb     <= 1'b0;
            ovf         <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;

            case ({push, issue})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: ;
            endcase

            if (host_stb && host_full) ovf <= 1'b1;

            if (issue) begin
                spk_data <= mem[rd_ptr];
                spk_stb  <= 1'b1;
                cnt_q    <= '0;
            end else begin
                spk_stb <= 1'b0;
                if (state_q == WAIT_LOW) cnt_q <= cnt_q + 1'b1;
            end

            // On a timeout the code counts as consumed and the FSM goes back
            // to IDLE.
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_allophone_feeder.sv
// -----------------------------------------------------------------------------
// tb_allophone_feeder
//
// Self-checking bench for allophone_feeder. Every accepted host write pushes
// its code onto a scoreboard queue. A monitor pops the queue on each spk_stb
// and compares spk_data with the popped code. Directed sequences cover reset,
// latency, full/overflow, the ldq handshake, timeout, flush and reset while a
// handshake is in progress.
// -----------------------------------------------------------------------------
module tb_allophone_feeder;

    localparam int FIFO_AW     = 4;
    localparam int LDQ_TIMEOUT = 256;

    logic             clk;
    logic             rst;
    logic [5:0]       host_data;
    logic             host_stb;
    logic             host_full;
    logic [FIFO_AW:0] host_level;
    logic             flush;
    logic             spk_ldq;
    logic [5:0]       spk_data;
    logic             spk_stb;
    logic             busy;
    logic             ovf;
    logic             timeout_err;

    allophone_feeder #(
        .FIFO_AW     (FIFO_AW),
        .LDQ_TIMEOUT (LDQ_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host_data   (host_data),
        .host_stb    (host_stb),
        .host_full   (host_full),
        .host_level  (host_level),
        .flush       (flush),
        .spk_ldq     (spk_ldq),
        .spk_data    (spk_data),
        .spk_stb     (spk_stb),
        .busy        (busy),
        .ovf         (ovf),
        .timeout_err (timeout_err)
    );

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         strobe_cnt = 0;
    int         stb_cyc    = 0;
    int         cyc        = 0;
    logic       prev_stb   = 1'b0;
    logic [5:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Strobe monitor: samples 2 time units after the active edge.
    always begin
        logic [5:0] exp_code;
        @(posedge clk);
        #2;
        if (!rst && spk_stb) begin
            check("stb_width", 32'(prev_stb), 0);
            strobe_cnt++;
            stb_cyc = cyc;
            if (sb.size() == 0) begin
                check("sb_depth_at_stb", sb.size(), 1);
            end else begin
                exp_code = sb.pop_front();
                check("spk_data", 32'(spk_data), 32'(exp_code));
            end
        end
        prev_stb = spk_stb;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_code(input logic [5:0] code, input bit accept);
        host_data = code;
        host_stb  = 1'b1;
        if (accept) sb.push_back(code);
        @(negedge clk);
        host_stb  = 1'b0;
    endtask

    task automatic wait_stb(input int target, input int budget);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("stb_wait", strobe_cnt, target);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"}, 32'(host_level), 0);
        check({tag, "_full"},  32'(host_full),  0);
        check({tag, "_data"},  32'(spk_data),   0);
        check({tag, "_stb"},   32'(spk_stb),    0);
        check({tag, "_ovf"},   32'(ovf),        0);
        check({tag, "_terr"},  32'(timeout_err), 0);
        check({tag, "_busy"},  32'(busy),       0);
    endtask

    initial begin
        int base;
        int s1;
        int terr_cyc;
        int n;

        rst       = 1'b1;
        host_data = '0;
        host_stb  = 1'b0;
        flush     = 1'b0;
        spk_ldq   = 1'b0;
        repeat (3) tick();
        check_reset_values("rst0");
        rst = 1'b0;

        // ---- 1: single code, two-edge latency ------------------------------
        spk_ldq = 1'b1;
        tick();
        write_code(6'h2A, 1'b1);
        check("t1_level_after_wr", 32'(host_level), 1);
        check("t1_no_stb_yet", strobe_cnt, 0);
        tick();
        check("t1_stb_cnt", strobe_cnt, 1);
        check("t1_level_after_pop", 32'(host_level), 0);
        check("t1_busy_wait", 32'(busy), 1);
        tick();
        check("t1_stb_dropped", 32'(spk_stb), 0);
        check("t1_busy_still", 32'(busy), 1);
        spk_ldq = 1'b0;
        tick();
        check("t1_busy_idle", 32'(busy), 0);
        check("t1_data_hold", 32'(spk_data), 32'h2A);
        spk_ldq = 1'b1;
        tick();

        // ---- 2: fill to full, overflow, drain in order ---------------------
        spk_ldq = 1'b0;
        base = strobe_cnt;
        for (int i = 0; i < 16; i++) write_code(6'(8'h10 + i), 1'b1);
        check("t2_level16", 32'(host_level), 16);
        check("t2_full", 32'(host_full), 1);
        check("t2_ovf_pre", 32'(ovf), 0);
        write_code(6'h3F, 1'b0);
        check("t2_ovf", 32'(ovf), 1);
        check("t2_level_hold", 32'(host_level), 16);
        spk_ldq = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            wait_stb(base + k, 10);
            spk_ldq = 1'b0;
            tick();
            spk_ldq = 1'b1;
        end
        repeat (4) tick();
        check("t2_total_stb", strobe_cnt - base, 16);
        check("t2_level_empty", 32'(host_level), 0);
        check("t2_sb_empty", sb.size(), 0);

        // ---- 3: core model toggling ldq ------------------------------------
        base = strobe_cnt;
        write_code(6'h01, 1'b1);
        write_code(6'h02, 1'b1);
        write_code(6'h03, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            wait_stb(base + k, 10);
            repeat (3) tick();
            check("t3_no_extra_high", strobe_cnt, base + k);
            spk_ldq = 1'b0;
            repeat (40) tick();
            check("t3_no_stb_low", strobe_cnt, base + k);
            spk_ldq = 1'b1;
        end
        tick();
        check("t3_level_empty", 32'(host_level), 0);

        // ---- 4: ldq stuck high -> timeout ----------------------------------
        base = strobe_cnt;
        write_code(6'h15, 1'b1);
        write_code(6'h2B, 1'b1);
        wait_stb(base + 1, 10);
        s1 = stb_cyc;
        check("t4_terr_pre", 32'(timeout_err), 0);
        n = 0;
        while (!timeout_err && n < LDQ_TIMEOUT + 50) begin
            tick();
            n++;
        end
        terr_cyc = cyc;
        check("t4_terr", 32'(timeout_err), 1);
        check("t4_terr_latency", terr_cyc - s1, LDQ_TIMEOUT);
        wait_stb(base + 2, 5);
        check("t4_second_stb_delay", stb_cyc - terr_cyc, 1);
        spk_ldq = 1'b0;
        tick();
        spk_ldq = 1'b1;
        tick();

        // ---- 5: flush mid WAIT_LOW with a concurrent write -----------------
        base = strobe_cnt;
        write_code(6'h33, 1'b1);
        wait_stb(base + 1, 10);
        for (int i = 0; i < 5; i++) write_code(6'(8'h20 + i), 1'b0);
        check("t5_level5", 32'(host_level), 5);
        check("t5_ovf_sticky", 32'(ovf), 1);
        check("t5_terr_sticky", 32'(timeout_err), 1);
        flush     = 1'b1;
        host_stb  = 1'b1;
        host_data = 6'h3E;
        tick();
        flush     = 1'b0;
        host_stb  = 1'b0;
        check("t5_level0", 32'(host_level), 0);
        check("t5_busy0", 32'(busy), 0);
        check("t5_ovf0", 32'(ovf), 0);
        check("t5_terr0", 32'(timeout_err), 0);
        check("t5_data_kept", 32'(spk_data), 32'h33);
        spk_ldq = 1'b0;
        tick();
        spk_ldq = 1'b1;
        repeat (8) tick();
        check("t5_no_more_stb", strobe_cnt, base + 1);

        // ---- 6: reset during WAIT_LOW and during a write -------------------
        base = strobe_cnt;
        write_code(6'h0C, 1'b1);
        wait_stb(base + 1, 10);
        write_code(6'h0D, 1'b1);
        check("t6_level1", 32'(host_level), 1);
        rst       = 1'b1;
        host_stb  = 1'b1;
        host_data = 6'h0E;
        tick();
        host_stb  = 1'b0;
        sb.delete();
        check_reset_values("t6");
        rst = 1'b0;
        repeat (8) tick();
        check("t6_no_stb", strobe_cnt, base + 1);
        check("t6_level_after", 32'(host_level), 0);

        check("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
